// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the architectural PC, issues
//                word reads to instruction memory over a req/ready + rvalid
//                handshake, holds the returned word for decode, and selects
//                the next PC from PCSrc/PCTarget when decode accepts.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic        misaligned_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        err_q;
  logic        req_q;

  logic [31:0] pc_plus4_w;
  logic [31:0] next_pc_d;
  logic        next_aligned_w;
  logic        accept_w;

  // Sequential PC wraps naturally at 2^32; this is not treated as an error.
  assign pc_plus4_w     = pc_q + 32'd4;
  assign next_pc_d      = PCSrc ? PCTarget : pc_plus4_w;
  assign next_aligned_w = (next_pc_d[1:0] == 2'b00);
  assign accept_w       = (state_q == S_HOLD) && instr_ready;

  // Request is masked by reset so nothing reaches memory while it is held.
  assign imem_req       = req_q && !reset;
  assign imem_addr      = pc_q;
  assign PC             = pc_q;
  assign PCPlus4        = pc_plus4_w;
  assign Instr          = instr_q;
  assign instr_valid    = valid_q;
  assign misaligned_err = err_q;

  // Fetch FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b1;
    end else begin
      case (state_q)
        S_REQ: begin
          // PC is untouched here, so the address stays stable under backpressure.
          if (imem_ready) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (accept_w) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if (next_aligned_w) begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end else begin
              // PC keeps the faulting instruction's address for diagnosis.
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        S_ERR: begin
          // Terminal until reset.
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_ERR;
          err_q   <= 1'b1;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
